alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request; sampled only while idle (busy=0).
REQ-005 Port: op  input  3  operation code, latched with start.
REQ-006 Port: a, b  input  WIDTH each  operands, latched with start.
REQ-007 Port: c  output  WIDTH  registered result (low half for MUL).
REQ-008 Port: c_hi  output  WIDTH  registered high half of MUL product; 0 for other ops.
REQ-009 Port: zero  output  1  registered; 1 when c==0 (and c_hi==0 for MUL).
REQ-010 Port: carry  output  1  registered carry/borrow/shift-out flag.
REQ-011 Port: ovf  output  1  registered signed overflow flag.
REQ-012 Port: busy  output  1  high while a multi-cycle operation is in progress.
REQ-013 Port: done  output  1  one-cycle pulse marking new valid c/c_hi/flags.

Function
REQ-014 Op codes SHALL be: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL (a<<1), 6 SHR (a>>1 logical), 7 MUL (see REQ-022).
REQ-015 States SHALL be IDLE and MUL only; IDLE->MUL on start with op=7 (macro defined); MUL->IDLE after the final iteration.
REQ-016 Ops 0-6: start sampled high in IDLE at edge k SHALL register c and flags at edge k and assert done for the cycle after edge k (latency 1); busy stays 0.
REQ-017 ADD: carry=bit WIDTH of a+b; ovf=signs of a,b equal and differ from c.
REQ-018 SUB: carry=1 when a<b unsigned (borrow); ovf=signs of a,b differ and sign of c differs from a.
REQ-019 AND/OR/XOR: carry=0, ovf=0. SHL: carry=a[WIDTH-1]; SHR: carry=a[0]; ovf=0 for shifts.
REQ-020 All results SHALL wrap modulo 2^WIDTH; c_hi=0 for ops 0-6.
REQ-021 start while busy=1 SHALL be ignored; no queuing.
REQ-022 MUL: unsigned shift-add, one bit of b per cycle; start at edge k, busy high from after edge k through edge k+WIDTH, done pulses the cycle after edge k+WIDTH; product written to {c_hi,c} only at completion.
REQ-023 MUL flags: carry=(c_hi!=0); ovf=0.
REQ-024 c, c_hi and flags SHALL hold their last values until the next completion; inputs changing mid-MUL SHALL not affect the result.
REQ-025 start in the cycle done is high SHALL be accepted (back-to-back operations, no idle gap).
REQ-026 a=0 or b=0 in MUL SHALL still take the full WIDTH cycles.

Reset
REQ-027 rst high SHALL immediately force state IDLE, c=0, c_hi=0, zero=1, carry=0, ovf=0, busy=0, done=0, iteration counter=0.
REQ-028 rst during MUL SHALL abort the operation with no done pulse; first start after rst deasserts is accepted normally.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN: when defined, op 7 is MUL per REQ-022; when undefined, op 7 is unsigned set-less-than (c=1 if a<b else 0, carry=0, ovf=0) with latency 1, the MUL state and counter are not built, and busy is constant 0.

Verification (WIDTH=8)
REQ-030 Bench SHALL cover: ADD a=200,b=100 -> c=44, carry=1, ovf=0, done one cycle after start.
REQ-031 SUB a=0x80,b=0x01 -> c=0x7F, carry=0, ovf=1; SUB a=5,b=5 -> c=0, zero=1.
REQ-032 MUL (macro on) a=13,b=10 -> busy 8 cycles, then c=130, c_hi=0, carry=0; a=255,b=255 -> c=0x01, c_hi=0xFE, carry=1.
REQ-033 start pulsed during MUL busy with op=0 -> ignored, MUL result unchanged; start in done cycle -> accepted.
REQ-034 rst asserted at 4th MUL cycle -> outputs at reset values immediately, no done; next ADD 2+5 -> c=7.
REQ-035 Macro off: op=7 a=3,b=9 -> c=1 after one cycle, busy never high.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus an optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multi-cycle MUL for op 7; otherwise op 7 is unsigned set-less-than.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_OP7 = 3'd7;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;

    // Extra top bit of sum/diff yields carry-out and borrow directly.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res       = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res       = {a[WIDTH-2:0], 1'b0};
                res_carry = a[WIDTH-1];
            end
            OP_SHR: begin
                res       = {1'b0, a[WIDTH-1:1]};
                res_carry = a[0];
            end
            OP_OP7: begin
`ifdef ALU_SEQ_MUL_EN
                res = '0;
`else
                res = {{(WIDTH-1){1'b0}}, (a < b)};
`endif
            end
            default: res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Operands are captured into mcand/mplier so input changes mid-MUL are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            c      <= '0;
            c_hi   <= '0;
            zero   <= 1'b1;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_OP7) begin
                            state  <= MUL;
                            busy   <= 1'b1;
                            count  <= '0;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                        end else begin
                            c     <= res;
                            c_hi  <= '0;
                            zero  <= (res == '0);
                            carry <= res_carry;
                            ovf   <= res_ovf;
                            done  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // Always runs all WIDTH iterations, even for zero operands.
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        count <= '0;
                        c     <= acc_next[WIDTH-1:0];
                        c_hi  <= acc_next[2*WIDTH-1:WIDTH];
                        zero  <= (acc_next == '0);
                        carry <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                        ovf   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    assign busy = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c     <= '0;
            c_hi  <= '0;
            zero  <= 1'b1;
            carry <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                c     <= res;
                c_hi  <= '0;
                zero  <= (res == '0);
                carry <= res_carry;
                ovf   <= res_ovf;
                done  <= 1'b1;
            end
        end
    end

`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): vector table for single-cycle ops plus
// hand-written sequences for MUL timing, ignored starts, back-to-back and reset abort.
module tb_alu_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] c_hi;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             busy;
    logic             done;

    int num_checks = 0;
    int num_fails  = 0;
    int busy_seen  = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       zero;
        logic       carry;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .c     (c),
        .c_hi  (c_hi),
        .zero  (zero),
        .carry (carry),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy === 1'b1) busy_seen++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pulses start for one rising edge; returns at the falling edge right after it.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkResult(input string name, input logic [7:0] ec, input logic [7:0] ehi,
                               input logic ez, input logic ecy, input logic eov);
        checkOutput({name, ".done"}, done, 1);
        checkOutput({name, ".busy"}, busy, 0);
        checkOutput({name, ".c"}, c, ec);
        checkOutput({name, ".c_hi"}, c_hi, ehi);
        checkOutput({name, ".zero"}, zero, ez);
        checkOutput({name, ".carry"}, carry, ecy);
        checkOutput({name, ".ovf"}, ovf, eov);
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic runMul(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] prod, input logic ecy, input bit disturb);
        int cycles;
        int early_done;
        cycles     = 0;
        early_done = 0;
        applyStimulus(3'd7, x, y);
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (done === 1'b1) early_done++;
            if (disturb && cycles == 3) begin
                start = 1'b1;
                op    = 3'd0;
                a     = 8'h11;
                b     = 8'h22;
            end else if (disturb) begin
                start = 1'b0;
                a     = ~a;
                b     = b + 8'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({name, ".busy_cycles"}, cycles, 8);
        checkOutput({name, ".early_done"}, early_done, 0);
        checkResult(name, prod[7:0], prod[15:8], (prod == 16'd0), ecy, 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int done_seen;

        //                op     a      b      c      z     cy    ov
        vecs.push_back('{3'd0, 8'd200, 8'd100, 8'd44, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{3'd1, 8'd5, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd1, 8'd3, 8'd5, 8'hFE, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3'd5, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd6, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{3'd6, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
`ifndef ALU_SEQ_MUL_EN
        vecs.push_back('{3'd7, 8'd3, 8'd9, 8'h01, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 8'd9, 8'd3, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 8'd7, 8'd7, 8'h00, 1'b1, 1'b0, 1'b0});
`endif

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        checkOutput("reset.c", c, 0);
        checkOutput("reset.c_hi", c_hi, 0);
        checkOutput("reset.zero", zero, 1);
        checkOutput("reset.carry", carry, 0);
        checkOutput("reset.ovf", ovf, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkResult($sformatf("vec%0d", i), vecs[i].c, 8'h00, vecs[i].zero, vecs[i].carry, vecs[i].ovf);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.done_pulse", i), done, 0);
            checkOutput($sformatf("vec%0d.c_hold", i), c, vecs[i].c);
        end

`ifdef ALU_SEQ_MUL_EN
        runMul("mul_13x10", 8'd13, 8'd10, 16'd130, 1'b0, 1'b0);
        runMul("mul_255x255", 8'd255, 8'd255, 16'hFE01, 1'b1, 1'b0);

        // Start in the done cycle must be taken immediately and clear c_hi.
        start = 1'b1;
        op    = 3'd0;
        a     = 8'd2;
        b     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        checkResult("b2b_add", 8'd5, 8'd0, 1'b0, 1'b0, 1'b0);

        runMul("mul_disturb", 8'd13, 8'd10, 16'd130, 1'b0, 1'b1);
        runMul("mul_zero", 8'd0, 8'd77, 16'd0, 1'b0, 1'b0);

        applyStimulus(3'd0, 8'd2, 8'd3);
        checkResult("pre_abort", 8'd5, 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'd7, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        checkOutput("abort.busy_before", busy, 1);
`else
        applyStimulus(3'd4, 8'hF0, 8'h0F);
        checkResult("pre_reset", 8'hFF, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`endif
        #2 rst = 1'b1;
        #1;
        checkOutput("abort.c", c, 0);
        checkOutput("abort.c_hi", c_hi, 0);
        checkOutput("abort.zero", zero, 1);
        checkOutput("abort.carry", carry, 0);
        checkOutput("abort.busy", busy, 0);
        checkOutput("abort.done", done, 0);
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort.no_done", done_seen, 0);

        applyStimulus(3'd0, 8'd2, 8'd5);
        checkResult("post_reset_add", 8'd7, 8'd0, 1'b0, 1'b0, 1'b0);

`ifndef ALU_SEQ_MUL_EN
        checkOutput("busy_never_high", busy_seen, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
